regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
//
// PURPOSE
// Parametrised multi-port register file for the datapath. Generalises the
// single-write/two-read file to NUM_RD read ports and two write ports
// (ALU writeback, load writeback), with optional write-to-read bypass,
// optional registered read outputs and a per-register pending scoreboard
// for load-use hazard detection. Sits between decode and writeback.
//
// PARAMETERS
// DATA_W     32  register width in bits
// NUM_REGS   32  register count (power of two); register 0 is hard-wired to 0
// ADDR_W     $clog2(NUM_REGS)  address width (derived, do not override)
// NUM_RD     2   number of read ports (1..4)
// BYPASS     1   1: a same-cycle write is forwarded to combinational reads
// READ_REG   0   0: combinational reads; 1: reads registered, 1-cycle latency
//
// PORTS
// clk           in   1               clock; all state updates on rising edge
// reset         in   1               asynchronous, active-low reset
// wen0          in   1               write port 0 enable
// waddr0        in   ADDR_W          write port 0 address
// wdata0        in   DATA_W          write port 0 data
// wen1          in   1               write port 1 enable (priority over port 0)
// waddr1        in   ADDR_W          write port 1 address
// wdata1        in   DATA_W          write port 1 data
// read_addr     in   NUM_RD*ADDR_W   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
// read_data     out  NUM_RD*DATA_W   packed read data, port k at [k*DATA_W +: DATA_W]
// read_pending  out  NUM_RD          port k's register has an outstanding claim
// claim_en      in   1               mark claim_addr pending (load issued)
// claim_addr    in   ADDR_W          register being claimed
// register_v0   out  DATA_W          debug: contents of register 2, never bypassed
//
// BEHAVIOUR
// - Reset low (async): all registers, all pending bits and registered
//   read_data cleared to 0 immediately; writes/claims ignored while low.
// - Write: on rising edge, wenK && waddrK!=0 stores wdataK. Both ports
//   same nonzero address: port 1 data stored. Address 0 writes discarded.
// - Read, READ_REG=0: read_data[k] = 0 if read_addr[k]==0; else if
//   BYPASS and a write port targets read_addr[k] this cycle, that write's
//   data (port 1 over port 0); else stored value. Zero-cycle latency.
// - Read, READ_REG=1: read_data[k] captured at rising edge from the value
//   the register holds after that edge's writes (always write-first,
//   independent of BYPASS); valid one cycle after address presented.
// - Scoreboard: pending[r] set at edge by claim_en && claim_addr==r (r!=0);
//   cleared at edge by any enabled write to r. Claim and write to same r
//   in one cycle: pending set (new claim wins). Claim of 0 ignored.
// - read_pending[k] = pending[read_addr[k]], combinational, both READ_REG
//   modes; not cleared by bypass (consumer must stall until the clearing
//   edge when BYPASS=0, may use bypassed data when BYPASS=1 and write hits).
// - register_v0 = stored register 2, combinational; reset value 0.
// - Reset deasserted mid-sequence: first edge after release behaves
//   as a normal cycle; no state from before reset survives.
//
// TESTING
// 1. Reset low, then write 0xDEADBEEF to r5 via port 0 -> next cycle
//    read_addr[0]=5 gives 0xDEADBEEF; reset low again -> reads 0 at once.
// 2. Write 0x1234 to r0 -> reading r0 returns 0; register_v0 unaffected.
// 3. wen0/wen1 both to r7 with 0x11/0x22 -> r7 holds 0x22 afterwards.
// 4. BYPASS=1, READ_REG=0: write 0xCAFE to r9 while reading r9 -> same
//    cycle read_data=0xCAFE; BYPASS=0 -> old value, 0xCAFE next cycle.
// 5. claim r3 -> read_pending=1 from next cycle; write r3 -> pending 0
//    after that edge; claim+write r3 same cycle -> pending stays 1.
// 6. READ_REG=1, NUM_RD=4: four distinct addresses -> all data appear
//    one cycle later; write to r4 on same edge as read of r4 -> new value.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins), NUM_RD read ports with
// optional write bypass or registered reads, plus a per-register load-pending scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wen0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     wen1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] read_addr,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic [NUM_RD-1:0]        read_pending,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [DATA_W-1:0]        register_v0
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             pending_q, pending_d;

  // Port 1 is applied last so it wins a same-address collision; r0 stays zero.
  always_comb begin
    regs_d = regs_q;
    if (wen0 && (waddr0 != '0)) regs_d[waddr0] = wdata0;
    if (wen1 && (waddr1 != '0)) regs_d[waddr1] = wdata1;
    regs_d[0] = '0;
  end

  // A claim in the same cycle as a write to that register leaves it pending.
  always_comb begin
    pending_d = pending_q;
    if (wen0 && (waddr0 != '0)) pending_d[waddr0] = 1'b0;
    if (wen1 && (waddr1 != '0)) pending_d[waddr1] = 1'b0;
    if (claim_en && (claim_addr != '0)) pending_d[claim_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign register_v0 = regs_q[2];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr            = read_addr[k*ADDR_W +: ADDR_W];
    assign read_pending[k] = pending_q[addr];

    if (READ_REG != 0) begin : g_reg
      logic [DATA_W-1:0] rdData_q;
      // Registered reads see the post-write value of this edge, regardless of BYPASS.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdData_q <= '0;
        else        rdData_q <= regs_d[addr];
      end
      assign read_data[k*DATA_W +: DATA_W] = rdData_q;
    end else begin : g_comb
      logic [DATA_W-1:0] combData;
      always_comb begin
        combData = regs_q[addr];
        if (addr == '0)                                    combData = '0;
        else if ((BYPASS != 0) && wen1 && (waddr1 == addr)) combData = wdata1;
        else if ((BYPASS != 0) && wen0 && (waddr0 == addr)) combData = wdata0;
      end
      assign read_data[k*DATA_W +: DATA_W] = combData;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three instances (bypass, no bypass, registered reads)
// share one stimulus stream checked against an array-based model of the register file.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wen0, wen1, claimEn;
  logic [AW-1:0] waddr0, waddr1, claimAddr;
  logic [DW-1:0] wdata0, wdata1;
  logic [NR*AW-1:0] readAddr;
  logic [NR*DW-1:0] dataA, dataB, dataC;
  logic [NR-1:0]    pendA, pendB, pendC;
  logic [DW-1:0]    v0A, v0B, v0C;

  int total = 0;
  int bad   = 0;
  bit driverDone = 0;

  typedef struct packed {
    logic [NR*DW-1:0] expA;
    logic [NR*DW-1:0] expB;
    logic [NR*DW-1:0] expC;
    logic [NR-1:0]    expPend;
    logic [DW-1:0]    expV0;
  } expRec_t;

  expRec_t scoreQ[$];

  logic [DW-1:0]    modelRegs[32];
  bit               modelPend[32];
  logic [NR*DW-1:0] nextRegExp;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .NUM_REGS(32), .NUM_RD(NR), .BYPASS(1), .READ_REG(0)) dutA (
    .clk(clk), .reset(reset), .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1), .read_addr(readAddr),
    .read_data(dataA), .read_pending(pendA), .claim_en(claimEn),
    .claim_addr(claimAddr), .register_v0(v0A));

  regfile_mp #(.DATA_W(DW), .NUM_REGS(32), .NUM_RD(NR), .BYPASS(0), .READ_REG(0)) dutB (
    .clk(clk), .reset(reset), .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1), .read_addr(readAddr),
    .read_data(dataB), .read_pending(pendB), .claim_en(claimEn),
    .claim_addr(claimAddr), .register_v0(v0B));

  regfile_mp #(.DATA_W(DW), .NUM_REGS(32), .NUM_RD(NR), .BYPASS(1), .READ_REG(1)) dutC (
    .clk(clk), .reset(reset), .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1), .read_addr(readAddr),
    .read_data(dataC), .read_pending(pendC), .claim_en(claimEn),
    .claim_addr(claimAddr), .register_v0(v0C));

  function automatic logic [NR*AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [NR*AW-1:0] p;
    p[0*AW +: AW] = AW'(a0);
    p[1*AW +: AW] = AW'(a1);
    p[2*AW +: AW] = AW'(a2);
    p[3*AW +: AW] = AW'(a3);
    return p;
  endfunction

  // Drives one cycle of inputs at the falling edge, records what every output must
  // show during this cycle, then advances the model across the coming rising edge.
  task automatic applyStimulus(input bit r,
                               input bit w0e, input int wa0, input logic [DW-1:0] wd0,
                               input bit w1e, input int wa1, input logic [DW-1:0] wd1,
                               input logic [NR*AW-1:0] ra, input bit ce, input int ca);
    expRec_t rec;
    logic [AW-1:0] a;
    logic [DW-1:0] stored, byp;
    bit we0, we1;
    we0 = w0e && r;
    we1 = w1e && r;
    @(negedge clk);
    reset = r; wen0 = we0; waddr0 = AW'(wa0); wdata0 = wd0;
    wen1 = we1; waddr1 = AW'(wa1); wdata1 = wd1;
    readAddr = ra; claimEn = ce && r; claimAddr = AW'(ca);
    if (!r) begin
      for (int i = 0; i < 32; i++) begin
        modelRegs[i] = '0;
        modelPend[i] = 1'b0;
      end
      nextRegExp = '0;
    end
    rec.expC  = nextRegExp;
    rec.expV0 = modelRegs[2];
    for (int k = 0; k < NR; k++) begin
      a = ra[k*AW +: AW];
      stored = (a == 0) ? '0 : modelRegs[a];
      byp = stored;
      if (a != 0 && we0 && AW'(wa0) == a) byp = wd0;
      if (a != 0 && we1 && AW'(wa1) == a) byp = wd1;
      rec.expA[k*DW +: DW] = byp;
      rec.expB[k*DW +: DW] = stored;
      rec.expPend[k]       = (a == 0) ? 1'b0 : modelPend[a];
    end
    scoreQ.push_back(rec);
    if (r) begin
      if (we0 && wa0 != 0) begin modelRegs[wa0] = wd0; modelPend[wa0] = 1'b0; end
      if (we1 && wa1 != 0) begin modelRegs[wa1] = wd1; modelPend[wa1] = 1'b0; end
      if (ce && ca != 0) modelPend[ca] = 1'b1;
      for (int k = 0; k < NR; k++) begin
        a = ra[k*AW +: AW];
        nextRegExp[k*DW +: DW] = (a == 0) ? '0 : modelRegs[a];
      end
    end
  endtask

  task automatic compareVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input expRec_t rec);
    for (int k = 0; k < NR; k++) begin
      compareVal($sformatf("bypassRead%0d", k), dataA[k*DW +: DW], rec.expA[k*DW +: DW]);
      compareVal($sformatf("plainRead%0d", k),  dataB[k*DW +: DW], rec.expB[k*DW +: DW]);
      compareVal($sformatf("regRead%0d", k),    dataC[k*DW +: DW], rec.expC[k*DW +: DW]);
    end
    compareVal("pendingA", DW'(pendA), DW'(rec.expPend));
    compareVal("pendingB", DW'(pendB), DW'(rec.expPend));
    compareVal("pendingC", DW'(pendC), DW'(rec.expPend));
    compareVal("regV0A", v0A, rec.expV0);
    compareVal("regV0B", v0B, rec.expV0);
    compareVal("regV0C", v0C, rec.expV0);
  endtask

  // Monitor: pops one expectation per cycle, sampling mid-low-phase of the clock.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (scoreQ.size() > 0) checkOutput(scoreQ.pop_front());
      else if (driverDone) break;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NR*AW-1:0] ra;
    int rSel;
    reset = 1'b0; wen0 = 0; wen1 = 0; waddr0 = '0; waddr1 = '0;
    wdata0 = '0; wdata1 = '0; readAddr = '0; claimEn = 0; claimAddr = '0;
    for (int i = 0; i < 32; i++) begin modelRegs[i] = '0; modelPend[i] = 1'b0; end
    nextRegExp = '0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, pack4(5, 2, 0, 1), 0, 0);
    applyStimulus(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, pack4(5, 0, 0, 0), 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, pack4(5, 5, 2, 0), 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, pack4(5, 5, 2, 0), 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, pack4(5, 2, 0, 0), 0, 0);

    applyStimulus(1, 1, 2, 32'h0000_0A0A, 0, 0, 0, pack4(2, 0, 0, 0), 0, 0);
    applyStimulus(1, 1, 0, 32'h0000_1234, 0, 0, 0, pack4(0, 2, 0, 0), 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, pack4(0, 2, 0, 0), 0, 0);

    applyStimulus(1, 1, 7, 32'h11, 1, 7, 32'h22, pack4(7, 0, 0, 0), 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, pack4(7, 7, 0, 0), 0, 0);

    applyStimulus(1, 1, 9, 32'h0000_1111, 0, 0, 0, pack4(9, 0, 0, 0), 0, 0);
    applyStimulus(1, 1, 9, 32'h0000_CAFE, 0, 0, 0, pack4(9, 9, 0, 0), 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, pack4(9, 9, 0, 0), 0, 0);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, pack4(3, 0, 0, 0), 1, 3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, pack4(3, 0, 0, 0), 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 3, 32'h3333, pack4(3, 0, 0, 0), 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, pack4(3, 0, 0, 0), 1, 3);
    applyStimulus(1, 1, 3, 32'h4444, 0, 0, 0, pack4(3, 0, 0, 0), 1, 3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, pack4(3, 0, 0, 0), 1, 0);

    applyStimulus(1, 1, 4, 32'h0000_0004, 0, 0, 0, pack4(1, 2, 3, 4), 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 4, 32'h4040_4040, pack4(4, 7, 9, 5), 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, pack4(0, 0, 0, 0), 0, 0);

    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NR; k++) begin
        rSel = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
        ra[k*AW +: AW] = AW'(rSel);
      end
      applyStimulus(($urandom_range(0, 49) != 0),
                    $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                    ra, ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
    end
    driverDone = 1;
  end

endmodule
